// File: rtl/serial_add_4b_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// master: start/A/B/CIN out, busy/done/SUM/COUT in; slave mirrors.
interface serial_add_4b_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             COUT;

  modport master (
    output start, A, B, CIN,
    input  busy, done, SUM, COUT
  );

  modport slave (
    input  start, A, B, CIN,
    output busy, done, SUM, COUT
  );
endinterface

// File: rtl/serial_add_4b.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry flop, LSB first.
// Ports: clk, rst (sync, active-high), io (slave: start/A/B/CIN -> busy/done/SUM/COUT).
module serial_add_4b #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_4b_if.slave io
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             s;
  logic             c;

  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ carry;
    c      = (a_sh[0] & b_sh[0]) |
             (a_sh[0] & carry) |
             (b_sh[0] & carry);
    last   = (state == RUN) &&
             (cnt == CW'(WIDTH - 1));
    // DONE accepts start too, giving back-to-back operation
    accept = io.start &&
             ((state == IDLE) || (state == DONE));
    nstate = state;
    unique case (state)
      IDLE:    if (io.start) nstate = RUN;
      RUN:     if (last) nstate = DONE;
      DONE:    nstate = io.start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        a_sh  <= io.A;
        b_sh  <= io.B;
        carry <= io.CIN;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
        s_sh  <= {s, s_sh[WIDTH-1:1]};
        carry <= c;
        cnt   <= cnt + CW'(1);
      end
      // result registers move only on the completion edge
      if (last) begin
        sum_q  <= {s, s_sh[WIDTH-1:1]};
        cout_q <= c;
      end
    end
  end

  assign io.busy = (state == RUN);
  assign io.done = (state == DONE);
  assign io.SUM  = sum_q;
  assign io.COUT = cout_q;
endmodule

// File: tb/tb_serial_add_4b.sv
// Self-checking bench for serial_add_4b (WIDTH=4).
// Scoreboard queue of expected {COUT,SUM}; tasks per scenario.
module tb_serial_add_4b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] q[$];

  serial_add_4b_if #(.WIDTH(4)) io ();

  serial_add_4b #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci
  );
    return {1'b0, a} + {1'b0, b} + {4'b0, ci};
  endfunction

  // drive one start pulse; returns at the first negedge after the accept edge
  task automatic start_op(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci
  );
    io.A     = a;
    io.B     = b;
    io.CIN   = ci;
    io.start = 1'b1;
    q.push_back(model(a, b, ci));
    @(negedge clk);
    io.start = 1'b0;
  endtask

  // observe negedges (current one first) until done, bounded
  task automatic wait_done(
    output bit got,
    output int lat,
    output int busy_n
  );
    got    = 1'b0;
    lat    = 0;
    busy_n = 0;
    for (int k = 0; k < 12; k++) begin
      lat++;
      if (io.done) begin
        got = 1'b1;
        break;
      end
      if (io.busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int dn;
    rst      = 1'b1;
    io.start = 1'b1;
    io.A     = 4'b1111;
    io.B     = 4'b1111;
    io.CIN   = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({io.busy, io.done, io.COUT, io.SUM} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 0000000",
               {io.busy, io.done, io.COUT, io.SUM});
    end
    rst      = 1'b0;
    io.start = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (io.done || io.busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL reset_idle got %0d active cycles want 0", dn);
    end
  endtask

  task automatic test_basic();
    bit got;
    int lat;
    int bn;
    logic [4:0] e;
    start_op(4'b0011, 4'b1100, 1'b0);
    wait_done(got, lat, bn);
    checks++;
    if (bn !== 4) begin
      errors++;
      $display("FAIL basic_busy got %0d want 4", bn);
    end
    checks++;
    if (!got || lat !== 5) begin
      errors++;
      $display("FAIL basic_latency got %0d (done %0d) want 5", lat, got);
    end
    e = q.pop_front();
    checks++;
    if ({io.COUT, io.SUM} !== e) begin
      errors++;
      $display("FAIL basic_sum got %b want %b", {io.COUT, io.SUM}, e);
    end
    @(negedge clk);
    checks++;
    if (io.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse got %b want 0", io.done);
    end
  endtask

  task automatic test_carry();
    bit got;
    int lat;
    int bn;
    logic [4:0] e;
    logic [3:0] av[2] = '{4'b1111, 4'b1100};
    logic [3:0] bv[2] = '{4'b0001, 4'b1111};
    logic       cv[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      start_op(av[i], bv[i], cv[i]);
      wait_done(got, lat, bn);
      e = q.pop_front();
      checks++;
      if (!got || {io.COUT, io.SUM} !== e) begin
        errors++;
        $display("FAIL carry_%0d got %b (done %0d) want %b",
                 i, {io.COUT, io.SUM}, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    bit got;
    int lat;
    int bn;
    int dn;
    logic [4:0] e;
    logic [4:0] prev;
    prev = {io.COUT, io.SUM};
    start_op(4'b0101, 4'b0101, 1'b0);
    checks++;
    if ({io.COUT, io.SUM} !== prev) begin
      errors++;
      $display("FAIL hold_1 got %b want %b", {io.COUT, io.SUM}, prev);
    end
    @(negedge clk);
    io.start = 1'b1;
    io.A     = 4'b1111;
    io.B     = 4'b1111;
    @(negedge clk);
    io.start = 1'b0;
    checks++;
    if ({io.COUT, io.SUM} !== prev) begin
      errors++;
      $display("FAIL hold_3 got %b want %b", {io.COUT, io.SUM}, prev);
    end
    wait_done(got, lat, bn);
    e = q.pop_front();
    checks++;
    if (!got || lat !== 3 || {io.COUT, io.SUM} !== e) begin
      errors++;
      $display("FAIL ignored_sum got %b lat %0d want %b lat 3",
               {io.COUT, io.SUM}, lat, e);
    end
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (io.done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL ignored_single got %0d extra done want 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int lat;
    int bn;
    logic [4:0] e;
    io.A     = 4'd0;
    io.B     = 4'b1100;
    io.CIN   = 1'b0;
    io.start = 1'b1;
    q.push_back(model(4'd0, 4'b1100, 1'b0));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wait_done(got, lat, bn);
      checks++;
      if (!got || lat !== 5) begin
        errors++;
        $display("FAIL b2b_period_%0d got %0d want 5", i, lat);
      end
      e = q.pop_front();
      checks++;
      if ({io.COUT, io.SUM} !== e) begin
        errors++;
        $display("FAIL b2b_sum_%0d got %b want %b",
                 i, {io.COUT, io.SUM}, e);
      end
      if (i < 15) begin
        io.A = 4'(i + 1);
        q.push_back(model(4'(i + 1), 4'b1100, 1'b0));
      end else begin
        io.start = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit got;
    int lat;
    int bn;
    logic [4:0] e;
    start_op(4'b1010, 4'b0110, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(q.pop_front());
    @(negedge clk);
    checks++;
    if ({io.busy, io.done, io.COUT, io.SUM} !== 7'b0) begin
      errors++;
      $display("FAIL abort_state got %b want 0000000",
               {io.busy, io.done, io.COUT, io.SUM});
    end
    rst = 1'b0;
    start_op(4'b0001, 4'b0001, 1'b1);
    wait_done(got, lat, bn);
    e = q.pop_front();
    checks++;
    if (!got || lat !== 5 || {io.COUT, io.SUM} !== e) begin
      errors++;
      $display("FAIL abort_restart got %b lat %0d want %b lat 5",
               {io.COUT, io.SUM}, lat, e);
    end
    @(negedge clk);
  endtask

  initial begin
    io.start = 1'b0;
    io.A     = '0;
    io.B     = '0;
    io.CIN   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_4b.md
# serial_add_4b

Bit-serial WIDTH-bit adder with carry-in and start/done handshake. It is the addition counterpart of the team's 4-bit full subtractor (SUM/BORROW, A, B, CIN). It replaces the parallel carry chain with a single full-adder cell and a carry flip-flop. Operands are captured on start and one bit is processed per clock, LSB first. The registered result is presented with a one-cycle done pulse.

## Interface
- WIDTH, 4: operand/result width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising clk.
- A  input  WIDTH  augend; captured only on an accepted start.
- B  input  WIDTH  addend; captured only on an accepted start.
- CIN  input  1  carry-in; captured only on an accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; SUM/COUT newly valid.
- SUM  output  WIDTH  registered result, A+B+CIN modulo 2^WIDTH.
- COUT  output  1  registered carry-out, bit WIDTH of A+B+CIN.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Internal registers: a_sh, b_sh, s_sh (WIDTH each), carry (1), bit counter cnt (ceil(log2 WIDTH) bits).
- IDLE and start=1 at an edge:
  - a_sh<=A, b_sh<=B, carry<=CIN, cnt<=0.
  - Next state RUN.
- IDLE and start=0: stay in IDLE.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - c = majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by one.
  - s_sh<={s, s_sh[WIDTH-1:1]}; carry<=c; cnt<=cnt+1.
- RUN, edge where cnt==WIDTH-1:
  - SUM<={s, s_sh[WIDTH-1:1]}, COUT<=c.
  - Next state DONE.
- DONE: lasts exactly one cycle.
  - start=1 is accepted here with the same captures as in IDLE. Next state RUN (back-to-back operation).
  - Otherwise next state IDLE.
- start in RUN is ignored. Operands and CIN are not re-sampled.
- SUM and COUT change only on the completion edge and on reset. They hold the last result indefinitely, including through later RUN phases.
- Arithmetic is unsigned. The mathematical result {COUT,SUM} equals A+B+CIN exactly; no overflow flag.

## Timing
- Reset values: busy=0, done=0, SUM=0, COUT=0, state=IDLE. All internal registers are 0.
- busy is decoded combinationally from state and is 1 only in RUN.
- done is 1 only in DONE.
- Let E0 be the edge that accepts start:
  - busy is high for the WIDTH cycles after E0.
  - SUM/COUT update at edge E0+WIDTH.
  - done is high during the cycle after E0+WIDTH.
  - Latency from start to done is WIDTH+1 cycles (5 for WIDTH=4).
- Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- rst overrides start at the same edge.
- rst during RUN or DONE aborts the computation. At the next edge all outputs and state return to their reset values; no done pulse occurs.
- After rst deasserts, a start at the first edge is accepted.

## Test plan
- Reset: hold rst high 2 cycles with start=1, A=4'b1111, B=4'b1111 -> busy=0, done=0, SUM=0000, COUT=0; no done after release until a new start.
- Basic sum: A=0011, B=1100, CIN=0, start pulse -> busy high 4 cycles, done in the 5th cycle, SUM=1111, COUT=0.
- Carry ripple: A=1111, B=0001, CIN=0 -> SUM=0000, COUT=1. Second case A=1100, B=1111, CIN=1 (28) -> SUM=1100, COUT=1.
- Ignored start: start with A=0101, B=0101; re-assert start with A=1111, B=1111 in the second RUN cycle -> single done, SUM=1010, COUT=0; SUM holds the prior value until the completion edge.
- Back-to-back: start held high with A sweeping 0000..1111, B=1100, CIN=0 -> done every 5 cycles; each result equals A+12 (e.g. A=0101 -> SUM=0001, COUT=1).
- Abort: rst for one cycle at the third RUN cycle of A=1010, B=0110 -> no done, SUM=0000, COUT=0. A subsequent start with A=0001, B=0001, CIN=1 -> SUM=0011, COUT=0.
